// File: rtl/aes_dec_sched.sv
// rtl/aes_dec_sched.sv - round-robin scheduler in front of the pipelined AES-128 inverse cipher array
module aes_dec_sched #(
    parameter int NREQ         = 4,
    parameter int MAX_INFLIGHT = 32,
    parameter int TAG_DEPTH    = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*128-1:0]  req_data,
    input  logic [NREQ*128-1:0]  req_key,
    output logic [127:0]         pipe_key,
    output logic                 pipe_in_valid,
    output logic [127:0]         pipe_in,
    input  logic [127:0]         pipe_out,
    input  logic                 pipe_out_valid,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [127:0]         rsp_data,
    output logic [6:0]           inflight,
    output logic                 busy,
    output logic                 err
);

    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TAGW = $clog2(TAG_DEPTH);
    localparam logic [NREQ-1:0] ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, SWITCH} state_t;

    state_t          state;
    logic [127:0]    cur_key;
    logic            key_loaded;
    logic [IDXW-1:0] rr_ptr;
    logic            locked;
    logic [IDXW-1:0] g_lock;
    logic [IDXW-1:0] g_srch;
    logic            srch_found;
    logic [IDXW-1:0] g;
    logic            have_g;
    logic [127:0]    g_key;
    logic [127:0]    g_data;
    logic            key_match;
    logic            issue;
    logic            ret;
    logic            spurious;

    // Requester-ID FIFO: pipe latency is fixed, so returns arrive in issue order.
    logic [IDXW-1:0] id_mem [TAG_DEPTH];
    logic [TAGW-1:0] wr_ptr;
    logic [TAGW-1:0] rd_ptr;

    // Round-robin search for the first valid requester starting at rr_ptr.
    always_comb begin
        int idx;
        g_srch     = '0;
        srch_found = 1'b0;
        idx        = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!srch_found && req_valid[idx]) begin
                srch_found = 1'b1;
                g_srch     = IDXW'(idx);
            end
        end
    end

    // Grant selection, issue decision and handshake; a locked grant blocks all bypass.
    always_comb begin
        g         = locked ? g_lock : g_srch;
        have_g    = locked | srch_found;
        g_key     = req_key[{g, 7'd0} +: 128];
        g_data    = req_data[{g, 7'd0} +: 128];
        key_match = (g_key == cur_key);
        issue     = (state == RUN) && have_g && req_valid[g] && key_loaded && key_match
                    && (inflight < 7'(MAX_INFLIGHT));
        ret       = pipe_out_valid && (inflight != 7'd0);
        spurious  = pipe_out_valid && (inflight == 7'd0);
        req_ready = issue ? (ONE_HOT0 << g) : '0;
        busy      = (inflight != 7'd0) || (state != IDLE);
    end

    // Control FSM: key is only swapped in SWITCH, which is entered with the pipe empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cur_key    <= '0;
            pipe_key   <= '0;
            key_loaded <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req_valid) state <= RUN;
                end
                RUN: begin
                    if (have_g) begin
                        if (!key_loaded) begin
                            state <= SWITCH;
                        end else if (!key_match) begin
                            state <= ((inflight != 7'd0) || pipe_in_valid) ? DRAIN : SWITCH;
                        end
                    end else if (inflight == 7'd0) begin
                        state <= IDLE;
                    end
                end
                DRAIN: begin
                    if ((inflight == 7'd0) && !pipe_in_valid) state <= SWITCH;
                end
                SWITCH: begin
                    cur_key    <= g_key;
                    pipe_key   <= g_key;
                    key_loaded <= 1'b1;
                    state      <= RUN;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Issue path, grant lock, outstanding count, ID FIFO and response delivery.
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_in_valid <= 1'b0;
            pipe_in       <= '0;
            rr_ptr        <= '0;
            locked        <= 1'b0;
            g_lock        <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            inflight      <= '0;
            err           <= 1'b0;
            rsp_valid     <= '0;
            rsp_data      <= '0;
        end else begin
            pipe_in_valid <= issue;
            if (issue) begin
                pipe_in        <= g_data;
                id_mem[wr_ptr] <= g;
                wr_ptr         <= wr_ptr + 1'b1;
                rr_ptr         <= (g == IDXW'(NREQ - 1)) ? '0 : g + 1'b1;
                locked         <= 1'b0;
            end else if (!locked && srch_found) begin
                locked <= 1'b1;
                g_lock <= g_srch;
            end

            case ({issue, ret})
                2'b10:   inflight <= inflight + 7'd1;
                2'b01:   inflight <= inflight - 7'd1;
                default: inflight <= inflight;
            endcase

            if (spurious) err <= 1'b1;

            if (ret) begin
                rsp_valid <= ONE_HOT0 << id_mem[rd_ptr];
                rsp_data  <= pipe_out;
                rd_ptr    <= rd_ptr + 1'b1;
            end else begin
                rsp_valid <= '0;
            end
        end
    end

endmodule
